// File: rtl/fmul_operand_gen.sv
// Operand sequencer for the fmul test harness: IEEE-754 special-value sweep, then LFSR pairs,
// plus a copy of each pair delayed by the fmul pipeline depth for ILA capture.
//
// state   | meaning
// --------+--------------------------------------------------------------
// IDLE    | after reset, waiting for start
// SPECIAL | issuing the 64 special-value pairs, indexed by idx
// RANDOM  | issuing NUM_RANDOM LFSR pairs, indexed by rcnt
// DONE    | sequence complete, waiting for start to rerun
module fmul_operand_gen #(
  parameter logic [31:0] SEED1      = 32'h00000001,
  parameter logic [31:0] SEED2      = 32'h0000ACE1,
  parameter int          NUM_RANDOM = 1024,
  parameter int          LATENCY    = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        hold,
  output logic [31:0] op1,
  output logic [31:0] op2,
  output logic        op_valid,
  output logic [31:0] op1_aligned,
  output logic [31:0] op2_aligned,
  output logic        aligned_valid,
  output logic        busy,
  output logic        done,
  output logic [15:0] count
);

  typedef enum logic [1:0] {S_IDLE, S_SPECIAL, S_RANDOM, S_DONE} state_t;

  localparam logic [31:0] SEED1_EFF = (SEED1 == 32'd0) ? 32'd1 : SEED1;
  localparam logic [31:0] SEED2_EFF = (SEED2 == 32'd0) ? 32'd1 : SEED2;
  localparam logic [15:0] RLAST     = 16'(NUM_RANDOM - 1);
  localparam logic [31:0] MASK      = 32'h80200003;

  function automatic logic [31:0] special(input logic [2:0] i);
    case (i)
      3'd0:    return 32'h00000000;
      3'd1:    return 32'h80000000;
      3'd2:    return 32'h3F800000;
      3'd3:    return 32'hC0000000;
      3'd4:    return 32'h7F7FFFFF;
      3'd5:    return 32'h00800000;
      3'd6:    return 32'h7F800000;
      default: return 32'h7FC00000;
    endcase
  endfunction

  function automatic logic [31:0] lfsr_step(input logic [31:0] x);
    return x[0] ? ((x >> 1) ^ MASK) : (x >> 1);
  endfunction

  state_t      state_q, state_d;
  logic [5:0]  idx;
  logic [15:0] rcnt;
  logic [31:0] lfsr1, lfsr2;
  logic        issue, restart;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE: if (start) state_d = S_SPECIAL;
      S_SPECIAL:      if (!hold && idx == 6'd63) state_d = S_RANDOM;
      S_RANDOM:       if (!hold && rcnt == RLAST) state_d = S_DONE;
      default:        state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy    = (state_q == S_SPECIAL) || (state_q == S_RANDOM);
    done    = (state_q == S_DONE);
    issue   = busy && !hold;
    restart = (state_q == S_IDLE || state_q == S_DONE) && start;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idx      <= '0;
      rcnt     <= '0;
      lfsr1    <= SEED1_EFF;
      lfsr2    <= SEED2_EFF;
      op1      <= '0;
      op2      <= '0;
      op_valid <= 1'b0;
      count    <= '0;
    end else begin
      op_valid <= issue;
      if (restart) begin
        idx   <= '0;
        rcnt  <= '0;
        count <= '0;
        lfsr1 <= SEED1_EFF;
        lfsr2 <= SEED2_EFF;
      end else if (issue) begin
        count <= count + 16'd1;
        if (state_q == S_SPECIAL) begin
          op1 <= special(idx[5:3]);
          op2 <= special(idx[2:0]);
          idx <= idx + 6'd1;
        end else begin
          op1   <= lfsr1;
          op2   <= lfsr2;
          lfsr1 <= lfsr_step(lfsr1);
          lfsr2 <= lfsr_step(lfsr2);
          rcnt  <= rcnt + 16'd1;
        end
      end
    end
  end

  // Delay line runs every cycle, independent of hold, to match the free-running fmul.
  generate
    if (LATENCY == 0) begin : g_nodly
      assign aligned_valid = op_valid;
      assign op1_aligned   = op1;
      assign op2_aligned   = op2;
    end else begin : g_dly
      logic [64:0] dly [LATENCY];
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          for (int i = 0; i < LATENCY; i++) dly[i] <= '0;
        end else begin
          dly[0] <= {op_valid, op1, op2};
          for (int i = 1; i < LATENCY; i++) dly[i] <= dly[i-1];
        end
      end
      assign {aligned_valid, op1_aligned, op2_aligned} = dly[LATENCY-1];
    end
  endgenerate

endmodule

// File: doc/fmul_operand_gen.md
Name: fmul_operand_gen

Overview:
- Upstream stimulus stage for the on-board fmul test harness.
- Replaces the free-running per-field pattern generators with one sequencer that emits operand pairs on op1/op2.
- Sequence is a fixed IEEE-754 special-value sweep followed by LFSR pseudo-random pairs.
- Also supplies a copy of each pair delayed by the fmul pipeline depth, so the pair and result_debug can be captured together in the ILA.

Parameters:
- SEED1, 32'h00000001: LFSR1 seed for op1. A value of 0 is replaced by 1.
- SEED2, 32'h0000ACE1: LFSR2 seed for op2. A value of 0 is replaced by 1.
- NUM_RANDOM, 1024: number of random pairs. Legal range 1..65471, so that 64+NUM_RANDOM ≤ 65535.
- LATENCY, 2: fmul pipeline depth in cycles. Legal range 0..8.

Ports:
- clk, input, 1: system clock.
- reset, input, 1: asynchronous, active-low reset.
- start, input, 1: begin a sequence. Sampled only in IDLE or DONE.
- hold, input, 1: pause issue. Operands freeze and op_valid drops.
- op1, output, 32: operand 1 to fmul (registered).
- op2, output, 32: operand 2 to fmul (registered).
- op_valid, output, 1: op1/op2 carry a newly issued pair this cycle.
- op1_aligned, output, 32: op1 delayed by LATENCY cycles.
- op2_aligned, output, 32: op2 delayed by LATENCY cycles.
- aligned_valid, output, 1: op_valid delayed by LATENCY cycles.
- busy, output, 1: state is SPECIAL or RANDOM.
- done, output, 1: state is DONE.
- count, output, 16: number of pairs issued since the last start.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE; LFSR1=SEED1, LFSR2=SEED2 (zero seed replaced by 1).
  - idx=0, rcnt=0.
  - All outputs and all delay-line stages cleared to 0.
  - Reset asserted mid-sequence aborts the sequence immediately; no pending pair survives.
- States: IDLE, SPECIAL, RANDOM, DONE.
  - IDLE --start--> SPECIAL.
  - DONE --start--> SPECIAL. This restart clears count, idx and rcnt, and reloads both LFSRs from their seeds.
  - start is ignored in SPECIAL and RANDOM.
- Issue event: a clock edge with state∈{SPECIAL,RANDOM} and hold=0.
  - On an issue edge: op1/op2 load the current pair, op_valid<=1, count<=count+1.
  - On any other edge: op_valid<=0 and op1/op2 hold their value.
  - First valid pair therefore appears 2 edges after start is sampled.
- Special table T[0..7]: 00000000, 80000000, 3F800000, C0000000, 7F7FFFFF, 00800000, 7F800000, 7FC00000.
- SPECIAL state:
  - Pair idx (6 bits): op1=T[idx[5:3]], op2=T[idx[2:0]].
  - idx increments on each issue.
  - The issue edge of idx=63 moves the state to RANDOM.
- RANDOM state:
  - Pair = (LFSR1, LFSR2). The first random pair is exactly the two seeds.
  - On each issue, both LFSRs step, rcnt increments.
  - Step is Galois, mask 32'h80200003: x' = x[0] ? (x>>1)^mask : x>>1.
  - The issue edge with rcnt=NUM_RANDOM-1 moves the state to DONE.
- hold:
  - hold in SPECIAL/RANDOM stalls idx, rcnt, the LFSRs and count.
  - The next issue after release continues with the next unissued pair; no pair is skipped or repeated.
  - hold has no effect in IDLE or DONE.
- busy and done are decoded from the registered state.
- Delay line:
  - LATENCY-stage shift register of {op_valid, op1, op2}.
  - Shifts every clock regardless of hold, because fmul is free-running.
  - LATENCY=0: aligned outputs are wired directly to op_valid/op1/op2.
- count never wraps within a legal parameter range.

Test Plan:
- Reset values: hold reset=0 for 3 cycles with start=1 → all outputs 0, state IDLE; on release with start=0, outputs remain 0.
- Special sweep: pulse start=1 for one cycle →
  - op_valid=1 two edges later with (00000000,00000000);
  - next cycle (00000000,80000000);
  - 10th pair (idx 9) = (80000000,80000000);
  - 64th pair = (7FC00000,7FC00000);
  - count=64 at that point.
- Random start (defaults):
  - 65th pair = (00000001,0000ACE1);
  - 66th pair = (80200003,80205673);
  - busy=1 throughout the sequence.
- Hold:
  - Assert hold for 5 cycles after pair idx 20 is issued → op_valid=0 for 5 cycles, op1/op2 unchanged.
  - After release, next pair is idx 21: T[2],T[5] = (3F800000,00800000).
- Completion/restart with NUM_RANDOM=4:
  - done=1 and busy=0 after the 68th issue, count=68.
  - Pulse start → count restarts at 0 and the first pair is again (00000000,00000000).
  - start pulsed mid-RANDOM is ignored.
- Alignment and abort:
  - LATENCY=2: aligned_valid/op1_aligned track op_valid/op1 exactly 2 cycles later, including across a hold gap.
  - Drop reset=0 mid-RANDOM → all outputs, including the aligned outputs, read 0 immediately.
